vcve2_vrf_ctrl: RTL

Sequencer for one vector instruction over the memory-resident vector register file (VRF). On `start_i` it latches the register indices, loads the address-generation counters, then for each 32-bit word of the register reads vs1 and vs2, presents them to the vector ALU, and writes the result to vd. The VRF memory is accessed over the core's single-outstanding req/gnt/rvalid data port. The block sits between the vector decode stage and the data-memory port. It drives the control side of the VRF address generator and consumes the addresses it returns.

---
 rtl/vcve2_pkg.sv | 35 +++
 rtl/vcve2_vrf_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vcve2_pkg.sv
// Shared types and constants for the vector register file sequencer.
// Holds the sequencer state encoding, VRF geometry and base address.
// The first-phase helper keeps the LOAD and WT_WR decisions consistent.
package vcve2_pkg;

   localparam int unsigned VRF_WORDS_PER_REG = 4;
   localparam logic [31:0] VRF_START_ADDR    = 32'h0000_1000;

   typedef enum logic [3:0] {
      VRF_IDLE  = 4'd0,
      VRF_LOAD  = 4'd1,
      VRF_RD_A  = 4'd2,
      VRF_WT_A  = 4'd3,
      VRF_RD_B  = 4'd4,
      VRF_WT_B  = 4'd5,
      VRF_WR    = 4'd6,
      VRF_WT_WR = 4'd7,
      VRF_DONE  = 4'd8
   } vrf_ctrl_state_e;

   // First active phase of a word: read vs1, else read vs2, else write vd.
   function automatic vrf_ctrl_state_e vrf_first_phase(input logic use_rs1,
                                                       input logic use_rs2);
      vrf_ctrl_state_e st;
      if (use_rs1) begin
         st = VRF_RD_A;
      end else if (use_rs2) begin
         st = VRF_RD_B;
      end else begin
         st = VRF_WR;
      end
      return st;
   endfunction

endpackage

// File: rtl/vcve2_vrf_ctrl.sv
// Sequencer for one vector instruction over the memory-resident VRF.
// Latency: 2 cycles to first request, then 2 cycles per memory access per word.
// Backpressure: requests are held stable until data_gnt_i; waits indefinitely for rvalid.
module vcve2_vrf_ctrl
   import vcve2_pkg::*;
#(
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned WordsPerReg = VRF_WORDS_PER_REG
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [4:0]           rs1_i,
   input  logic [4:0]           rs2_i,
   input  logic [4:0]           rd_i,
   input  logic                 use_rs1_i,
   input  logic                 use_rs2_i,
   input  logic [31:0]          scalar_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [4:0]           agu_rs1_o,
   output logic [4:0]           agu_rs2_o,
   output logic [4:0]           agu_rd_o,
   output logic                 agu_load_o,
   output logic                 agu_get_rs1_o,
   output logic                 agu_get_rs2_o,
   output logic                 agu_get_rd_o,
   output logic                 agu_incr_o,
   input  logic [AddrWidth-1:0] agu_addr_i,
   output logic                 data_req_o,
   input  logic                 data_gnt_i,
   input  logic                 data_rvalid_i,
   output logic                 data_we_o,
   output logic [3:0]           data_be_o,
   output logic [AddrWidth-1:0] data_addr_o,
   output logic [31:0]          data_wdata_o,
   input  logic [31:0]          data_rdata_i,
   output logic [31:0]          alu_op_a_o,
   output logic [31:0]          alu_op_b_o,
   input  logic [31:0]          alu_result_i
);

   localparam int unsigned     CntW     = (WordsPerReg > 1) ? $clog2(WordsPerReg) : 1;
   localparam logic [CntW-1:0] LastWord = CntW'(WordsPerReg - 1);

   vrf_ctrl_state_e state_q, state_d;
   logic [4:0]      rs1_q, rs2_q, rd_q;
   logic            use_rs1_q, use_rs2_q;
   logic [31:0]     scalar_q, op_a_q, op_b_q;
   logic [CntW-1:0] word_cnt_q;

   // State register plus operand/instruction capture; reset clears everything.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= VRF_IDLE;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         use_rs1_q  <= 1'b0;
         use_rs2_q  <= 1'b0;
         scalar_q   <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         word_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == VRF_IDLE && start_i) begin
            rs1_q      <= rs1_i;
            rs2_q      <= rs2_i;
            rd_q       <= rd_i;
            use_rs1_q  <= use_rs1_i;
            use_rs2_q  <= use_rs2_i;
            scalar_q   <= scalar_i;
            word_cnt_q <= '0;
         end
         if (state_q == VRF_WT_A && data_rvalid_i) begin
            op_a_q <= data_rdata_i;
         end
         if (state_q == VRF_WT_B && data_rvalid_i) begin
            op_b_q <= data_rdata_i;
         end
         if (state_q == VRF_WT_WR && data_rvalid_i && word_cnt_q != LastWord) begin
            word_cnt_q <= word_cnt_q + 1'b1;
         end
      end
   end

   // Next-state and Moore control decode; agu_incr_o additionally gated by grant.
   always_comb begin
      state_d       = state_q;
      done_o        = 1'b0;
      agu_load_o    = 1'b0;
      agu_get_rs1_o = 1'b0;
      agu_get_rs2_o = 1'b0;
      agu_get_rd_o  = 1'b0;
      agu_incr_o    = 1'b0;
      data_req_o    = 1'b0;
      data_we_o     = 1'b0;
      data_be_o     = 4'h0;
      unique case (state_q)
         VRF_IDLE: begin
            if (start_i) state_d = VRF_LOAD;
         end
         VRF_LOAD: begin
            agu_load_o = 1'b1;
            state_d    = vrf_first_phase(use_rs1_q, use_rs2_q);
         end
         VRF_RD_A: begin
            agu_get_rs1_o = 1'b1;
            data_req_o    = 1'b1;
            if (data_gnt_i) begin
               agu_incr_o = 1'b1;
               state_d    = VRF_WT_A;
            end
         end
         VRF_WT_A: begin
            if (data_rvalid_i) state_d = use_rs2_q ? VRF_RD_B : VRF_WR;
         end
         VRF_RD_B: begin
            agu_get_rs2_o = 1'b1;
            data_req_o    = 1'b1;
            if (data_gnt_i) begin
               agu_incr_o = 1'b1;
               state_d    = VRF_WT_B;
            end
         end
         VRF_WT_B: begin
            if (data_rvalid_i) state_d = VRF_WR;
         end
         VRF_WR: begin
            agu_get_rd_o = 1'b1;
            data_req_o   = 1'b1;
            data_we_o    = 1'b1;
            data_be_o    = 4'hF;
            if (data_gnt_i) begin
               agu_incr_o = 1'b1;
               state_d    = VRF_WT_WR;
            end
         end
         VRF_WT_WR: begin
            if (data_rvalid_i) begin
               state_d = (word_cnt_q == LastWord) ? VRF_DONE
                                                  : vrf_first_phase(use_rs1_q, use_rs2_q);
            end
         end
         VRF_DONE: begin
            done_o  = 1'b1;
            state_d = VRF_IDLE;
         end
         default: state_d = VRF_IDLE;
      endcase
   end

   assign busy_o       = (state_q != VRF_IDLE);
   assign agu_rs1_o    = rs1_q;
   assign agu_rs2_o    = rs2_q;
   assign agu_rd_o     = rd_q;
   assign data_addr_o  = agu_addr_i;
   assign data_wdata_o = alu_result_i;
   assign alu_op_a_o   = use_rs1_q ? op_a_q : scalar_q;
   assign alu_op_b_o   = op_b_q;

endmodule
